// File: rtl/booth_daa_mac.sv
// Radix-4 Booth digit-serial MAC with dynamic accumulator alignment (shared exponent).
// Define BOOTH_DAA_NORM_EN to add a renormalisation state after each operation.
module booth_daa_mac #(
    parameter int unsigned XW = 4,
    parameter int unsigned ND = 2,
    parameter int unsigned AW = 10,
    parameter int unsigned EW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic            signed_x,
    input  logic [XW-1:0]   x,
    input  logic [2*ND-1:0] w,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   acc,
    output logic [EW-1:0]   exp,
    output logic            ovf
);

    localparam int unsigned KW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [KW-1:0] KLast = KW'(ND - 1);
    localparam logic [EW-1:0] EMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StNorm,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [XW:0]         x_q, x_d;
    logic [2*ND-1:0]     w_q, w_d;
    logic [KW-1:0]       k_q, k_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [EW-1:0]       exp_q, exp_d;
    logic                ovf_q, ovf_d;

    logic [2*ND:0]       w_ext;
    logic [2:0]          trip;
    logic                d_neg, d_one, d_two;
    logic signed [AW:0]  x_ext, mag, prod, term, t;
    logic [AW:0]         s;
    logic                fits, renorm;

    // Booth triplet for digit k, with an implicit zero below the multiplier LSB.
    always_comb begin
        w_ext = {w_q, 1'b0};
        trip  = 3'(w_ext >> {k_q, 1'b0});
    end

    always_comb begin
        d_neg = 1'b0;
        d_one = 1'b0;
        d_two = 1'b0;
        case (trip)
            3'b001, 3'b010: d_one = 1'b1;
            3'b011:         d_two = 1'b1;
            3'b100: begin
                d_neg = 1'b1;
                d_two = 1'b1;
            end
            3'b101, 3'b110: begin
                d_neg = 1'b1;
                d_one = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        x_ext  = {{(AW - XW){x_q[XW]}}, x_q};
        mag    = d_two ? (x_ext <<< 1) : (d_one ? x_ext : '0);
        prod   = d_neg ? -mag : mag;
        term   = prod <<< {k_q, 1'b0};
        t      = term >>> exp_q;
        s      = {acc_q[AW-1], acc_q} + t;
        fits   = (s[AW] == s[AW-1]);
        renorm = (exp_q != '0) && (acc_q[AW-1] == acc_q[AW-2]);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        w_d     = w_q;
        k_d     = k_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = {signed_x & x[XW-1], x};
                    w_d     = w;
                    k_d     = '0;
                    state_d = StMul;
                end
                if (clear) begin
                    acc_d = '0;
                    exp_d = '0;
                    ovf_d = 1'b0;
                end
            end
            StMul: begin
                if (fits) begin
                    acc_d = s[AW-1:0];
                end else if (exp_q != EMax) begin
                    acc_d = s[AW:1];
                    exp_d = exp_q + 1'b1;
                end else begin
                    acc_d = s[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
                    ovf_d = 1'b1;
                end
                if (k_q == KLast) begin
`ifdef BOOTH_DAA_NORM_EN
                    state_d = StNorm;
`else
                    state_d = StDone;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StNorm: begin
`ifdef BOOTH_DAA_NORM_EN
                if (renorm) begin
                    acc_d = {acc_q[AW-2:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end else begin
                    state_d = StDone;
                end
`else
                state_d = StDone;
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            w_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            w_q     <= w_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StMul) || (state_q == StNorm);
    assign done = (state_q == StDone);
    assign acc  = acc_q;
    assign exp  = exp_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_booth_daa_mac.sv
// Scoreboard bench for booth_daa_mac: one default instance and one with a 1-bit exponent,
// both driven by the same stimulus. Honours BOOTH_DAA_NORM_EN when defined.
module tb_booth_daa_mac;

    localparam int XW = 4;
    localparam int ND = 2;
    localparam int AW = 10;
    localparam int EMAX_A = 7;
    localparam int EMAX_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic signed_x = 1'b1;
    logic [XW-1:0] x_in = '0;
    logic [2*ND-1:0] w_in = '0;

    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic signed [AW-1:0] acc_a, acc_b;
    logic [2:0] exp_a;
    logic [0:0] exp_b;

    booth_daa_mac #(.XW(XW), .ND(ND), .AW(AW), .EW(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .signed_x(signed_x),
        .x(x_in), .w(w_in), .busy(busy_a), .done(done_a), .acc(acc_a), .exp(exp_a),
        .ovf(ovf_a)
    );

    booth_daa_mac #(.XW(XW), .ND(ND), .AW(AW), .EW(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .signed_x(signed_x),
        .x(x_in), .w(w_in), .busy(busy_b), .done(done_b), .acc(acc_b), .exp(exp_b),
        .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        int     ex;
        bit     ovf;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    longint m_acc[2];
    int     m_exp[2];
    bit     m_ovf[2];
    int     m_lat[2];
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint floor_shr(input longint v, input int e);
        longint d = longint'(1) << e;
        longint q = v / d;
        if (q * d != v && v < 0) q = q - 1;
        return q;
    endfunction

    // Reference model: integer arithmetic, pushes one expectation per instance.
    task automatic model_op(input logic [XW-1:0] x4, input bit sx, input logic [2*ND-1:0] w4,
                            input bit clr);
        longint xv, lo, hi, term, s;
        logic [2*ND:0] wb;
        int d, emax;
        exp_t e;
        xv = (sx && x4[XW-1]) ? longint'(x4) - (longint'(1) << XW) : longint'(x4);
        wb = {w4, 1'b0};
        lo = -(longint'(1) << (AW - 1));
        hi = (longint'(1) << (AW - 1)) - 1;
        for (int i = 0; i < 2; i++) begin
            emax = (i == 0) ? EMAX_A : EMAX_B;
            if (clr) begin
                m_acc[i] = 0;
                m_exp[i] = 0;
                m_ovf[i] = 0;
            end
            for (int k = 0; k < ND; k++) begin
                d = -2 * int'(wb[2*k+2]) + int'(wb[2*k+1]) + int'(wb[2*k]);
                term = longint'(d) * xv * (longint'(1) << (2 * k));
                s = m_acc[i] + floor_shr(term, m_exp[i]);
                if (s >= lo && s <= hi) begin
                    m_acc[i] = s;
                end else if (m_exp[i] < emax) begin
                    m_acc[i] = floor_shr(s, 1);
                    m_exp[i]++;
                end else begin
                    m_acc[i] = (s > hi) ? hi : lo;
                    m_ovf[i] = 1;
                end
            end
            m_lat[i] = ND + 1;
`ifdef BOOTH_DAA_NORM_EN
            while (m_exp[i] > 0 && m_acc[i] >= -(longint'(1) << (AW - 2)) &&
                   m_acc[i] < (longint'(1) << (AW - 2))) begin
                m_acc[i] = m_acc[i] * 2;
                m_exp[i]--;
                m_lat[i]++;
            end
            m_lat[i]++;
`endif
            e.acc = m_acc[i];
            e.ex  = m_exp[i];
            e.ovf = m_ovf[i];
            if (i == 0) sb_a.push_back(e);
            else sb_b.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_done", done_a, 0);
            end else begin
                e = sb_a.pop_front();
                check("a_acc", acc_a, e.acc);
                check("a_exp", exp_a, e.ex);
                check("a_ovf", ovf_a, e.ovf);
            end
        end
        if (done_b) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_done", done_b, 0);
            end else begin
                e = sb_b.pop_front();
                check("b_acc", acc_b, e.acc);
                check("b_exp", exp_b, e.ex);
                check("b_ovf", ovf_b, e.ovf);
            end
        end
    end

    // One operation; returns at the negedge of the later done pulse.
    task automatic run_op(input logic [XW-1:0] xv, input bit sx, input logic [2*ND-1:0] wv,
                          input bit clr, input bit poke);
        int n = 0;
        int na = 0;
        int nb = 0;
        @(negedge clk);
        x_in = xv;
        signed_x = sx;
        w_in = wv;
        clear = clr;
        start = 1'b1;
        model_op(xv, sx, wv, clr);
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        while ((na == 0 || nb == 0) && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_in_mul", busy_a, 1);
                if (poke) begin
                    start = 1'b1;
                    clear = 1'b1;
                    x_in = 4'b0101;
                    w_in = 4'b0111;
                end
            end else if (n == 2 && poke) begin
                start = 1'b0;
                clear = 1'b0;
            end
            if (done_a && na == 0) na = n;
            if (done_b && nb == 0) nb = n;
        end
        check("latency_a", na, m_lat[0]);
        check("latency_b", nb, m_lat[1]);
        check("busy_at_done", busy_a, 0);
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        x_in = 4'd3;
        signed_x = 1'b1;
        w_in = 4'd5;
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_acc_a", acc_a, 0);
        check("rst_exp_a", exp_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_acc_b", acc_b, 0);
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_exp[i] = 0;
            m_ovf[i] = 0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_done", done_a, 0);
        end
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_acc", acc_a, 0);
        check("reset_exp", exp_a, 0);
        check("reset_ovf", ovf_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        rst = 1'b1;

        run_op(4'd3, 1'b1, 4'd5, 1'b1, 1'b0);
        check("basic_acc", acc_a, 15);
        check("basic_exp", exp_a, 0);
        run_op(4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0);
        check("neg_acc", acc_a, 64);
        run_op(4'b1100, 1'b0, 4'b0011, 1'b1, 1'b0);
        check("unsigned_x_acc", acc_a, 36);

        run_op(4'd7, 1'b1, 4'd7, 1'b1, 1'b0);
        repeat (9) run_op(4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
        check("realign10_acc", acc_a, 490);
        check("realign10_exp", exp_a, 0);
        run_op(4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
        check("realign11_acc", acc_a, 269);
        check("realign11_exp", exp_a, 1);
        run_op(4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
        check("realign12_acc", acc_a, 293);

        repeat (9) run_op(4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
        check("sat21_acc_b", acc_b, 509);
        run_op(4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
        check("sat22_acc_b", acc_b, 511);
        check("sat22_exp_b", exp_b, 1);
        check("sat22_ovf_b", ovf_b, 1);
        run_op(4'd3, 1'b1, 4'd5, 1'b1, 1'b0);
        check("sat_clear_ovf_b", ovf_b, 0);

        run_op(4'd7, 1'b1, 4'd7, 1'b1, 1'b0);
        repeat (11) run_op(4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
        run_op(4'b1000, 1'b1, 4'd7, 1'b0, 1'b0);
        check("norm1_acc", acc_a, 265);
        check("norm1_exp", exp_a, 1);
        run_op(4'b1000, 1'b1, 4'd7, 1'b0, 1'b0);
`ifdef BOOTH_DAA_NORM_EN
        check("norm2_acc", acc_a, 474);
        check("norm2_exp", exp_a, 0);
`else
        check("norm2_acc", acc_a, 237);
        check("norm2_exp", exp_a, 1);
`endif

        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_exp[i] = 0;
            m_ovf[i] = 0;
        end
        @(negedge clk);
        check("idle_clear_acc", acc_a, 0);
        check("idle_clear_exp", exp_a, 0);

        run_op(4'd3, 1'b1, 4'd5, 1'b1, 1'b1);
        check("start_while_busy_acc", acc_a, 15);

        reset_mid_op();
        run_op(4'd3, 1'b1, 4'd5, 1'b0, 1'b0);
        check("after_rst_acc", acc_a, 15);

        repeat (2) @(negedge clk);
        check("sb_a_left", sb_a.size(), 0);
        check("sb_b_left", sb_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
